// File: rtl/db_pkg.sv
// Shared definitions for the multi-channel debouncer: channel state
// encoding and a width helper for the prescaler and stability counters.
package db_pkg;

  // Channel states. Bit 1 of the encoding is the debounced level.
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b11,
    WAIT0 = 2'b10
  } db_state_e;

  // Number of bits needed to hold the values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: input synchroniser, tick-sampled stability FSM
// with consecutive-sample counter, registered level and edge pulses.
module debounce_channel
  import db_pkg::*;
#(
  parameter int STABLE_TICKS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_out,
  output logic o_rise,
  output logic o_fall
);

  localparam int            CW       = clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  db_state_e              r_state;
  db_state_e              w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   r_out;
  logic                   w_out_nxt;
  logic                   r_rise;
  logic                   r_fall;

  assign w_s = r_sync[SYNC_STAGES-1];

  // Shift the raw pin through the synchroniser chain every clock.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignment lets each stage capture its predecessor's
    // pre-edge value; blocking here would collapse the chain into one flop.
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
    end
  end

  // Next state and counter; only a sample tick can move the FSM.
  always_comb begin
    // NOTE: hold values are assigned before the case so every path drives
    // both signals and no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_tick) begin
      case (r_state)
        ZERO: begin
          if (w_s) begin
            w_state_nxt = WAIT1;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        WAIT1: begin
          if (!w_s) begin
            w_state_nxt = ZERO;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        ONE: begin
          if (!w_s) begin
            w_state_nxt = WAIT0;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        WAIT0: begin
          if (w_s) begin
            w_state_nxt = ONE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ZERO;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = ZERO;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign w_out_nxt = (w_state_nxt == ONE) || (w_state_nxt == WAIT0);

  // State, counter, level and one-cycle edge pulses aligned with the level change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ZERO;
      r_cnt   <= '0;
      r_out   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_rise  <= w_out_nxt & ~r_out;
      r_fall  <= ~w_out_nxt & r_out;
    end
  end

  assign o_out  = r_out;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/multi_debouncer.sv
// N-channel debouncer top: shared sample-tick prescaler feeding one
// debounce_channel instance per input bit.
module multi_debouncer
  import db_pkg::*;
#(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = 32,
  parameter int STABLE_TICKS = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                tick
);

  localparam int            QW     = clog2(TICK_DIV);
  localparam logic [QW-1:0] Q_LAST = QW'(TICK_DIV - 1);
  localparam logic [QW-1:0] Q_ONE  = QW'(1);

  logic [QW-1:0] r_q;
  logic          w_tick;

  // Tick is decoded from the counter and gated by enable so a frozen
  // prescaler never leaves the channels seeing a stuck tick.
  assign w_tick = en && (r_q == Q_LAST);

  // Prescaler: count 0..TICK_DIV-1 while enabled, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= w_tick ? '0 : r_q + Q_ONE;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .STABLE_TICKS(STABLE_TICKS),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .i_tick(w_tick),
      .i_raw (in[g]),
      .o_out (out[g]),
      .o_rise(rise[g]),
      .o_fall(fall[g])
    );
  end

  assign tick = w_tick;

endmodule
